// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures the ALU result and ID control fields, maps overflow and
// interrupts onto exception codes, suppresses side effects of faulting slots, counts overflows.
module ex_mem_reg #(
  parameter int PC_W  = 30,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             int_detect,
  input  logic [PC_W-1:0]  id_pc,
  input  logic             id_en,
  input  logic             id_br_flag,
  input  logic [1:0]       id_mem_op,
  input  logic [31:0]      id_mem_wr_data,
  input  logic [1:0]       id_ctrl_op,
  input  logic [4:0]       id_dst_addr,
  input  logic             id_gpr_we,
  input  logic [2:0]       id_exp_code,
  input  logic [31:0]      alu_out,
  input  logic             alu_of,
  output logic [PC_W-1:0]  ex_pc,
  output logic             ex_en,
  output logic             ex_br_flag,
  output logic [1:0]       ex_mem_op,
  output logic [31:0]      ex_mem_wr_data,
  output logic [1:0]       ex_ctrl_op,
  output logic [4:0]       ex_dst_addr,
  output logic             ex_gpr_we,
  output logic [2:0]       ex_exp_code,
  output logic [31:0]      ex_out,
  output logic [CNT_W-1:0] ex_of_cnt
);

  localparam logic [2:0] EXP_NONE     = 3'd0;
  localparam logic [2:0] EXP_EXT_INT  = 3'd1;
  localparam logic [2:0] EXP_OVERFLOW = 3'd3;

  logic [PC_W-1:0]  pc_q,       pc_d;
  logic             en_q,       en_d;
  logic             br_flag_q,  br_flag_d;
  logic [1:0]       mem_op_q,   mem_op_d;
  logic [31:0]      wr_data_q,  wr_data_d;
  logic [1:0]       ctrl_op_q,  ctrl_op_d;
  logic [4:0]       dst_addr_q, dst_addr_d;
  logic             gpr_we_q,   gpr_we_d;
  logic [2:0]       exp_code_q, exp_code_d;
  logic [31:0]      out_q,      out_d;
  logic [CNT_W-1:0] of_cnt_q,   of_cnt_d;

  logic id_fault;
  logic of_fault;
  logic kill_side_fx;

  // An ID-side exception outranks overflow; invalid slots never raise overflow.
  assign id_fault     = id_en && (id_exp_code != EXP_NONE);
  assign of_fault     = id_en && (id_exp_code == EXP_NONE) && alu_of;
  assign kill_side_fx = !id_en || id_fault || of_fault;

  always_comb begin
    pc_d       = pc_q;
    en_d       = en_q;
    br_flag_d  = br_flag_q;
    mem_op_d   = mem_op_q;
    wr_data_d  = wr_data_q;
    ctrl_op_d  = ctrl_op_q;
    dst_addr_d = dst_addr_q;
    gpr_we_d   = gpr_we_q;
    exp_code_d = exp_code_q;
    out_d      = out_q;
    of_cnt_d   = of_cnt_q;

    if (stall) begin
      // hold everything
    end else if (flush || int_detect) begin
      pc_d       = '0;
      en_d       = 1'b0;
      br_flag_d  = 1'b0;
      mem_op_d   = '0;
      wr_data_d  = '0;
      ctrl_op_d  = '0;
      dst_addr_d = '0;
      gpr_we_d   = 1'b0;
      exp_code_d = EXP_NONE;
      out_d      = '0;
      if (!flush) begin
        // interrupt keeps the PC so the handler knows where to resume
        pc_d       = id_pc;
        en_d       = id_en;
        exp_code_d = EXP_EXT_INT;
      end
    end else begin
      pc_d       = id_pc;
      en_d       = id_en;
      br_flag_d  = id_br_flag;
      mem_op_d   = id_mem_op;
      wr_data_d  = id_mem_wr_data;
      ctrl_op_d  = id_ctrl_op;
      dst_addr_d = id_dst_addr;
      gpr_we_d   = id_gpr_we;
      exp_code_d = id_exp_code;
      out_d      = alu_out;
      if (kill_side_fx) begin
        gpr_we_d = 1'b0;
        mem_op_d = '0;
      end
      if (of_fault) begin
        exp_code_d = EXP_OVERFLOW;
        if (of_cnt_q != {CNT_W{1'b1}}) of_cnt_d = of_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      en_q       <= 1'b0;
      br_flag_q  <= 1'b0;
      mem_op_q   <= '0;
      wr_data_q  <= '0;
      ctrl_op_q  <= '0;
      dst_addr_q <= '0;
      gpr_we_q   <= 1'b0;
      exp_code_q <= EXP_NONE;
      out_q      <= '0;
      of_cnt_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      en_q       <= en_d;
      br_flag_q  <= br_flag_d;
      mem_op_q   <= mem_op_d;
      wr_data_q  <= wr_data_d;
      ctrl_op_q  <= ctrl_op_d;
      dst_addr_q <= dst_addr_d;
      gpr_we_q   <= gpr_we_d;
      exp_code_q <= exp_code_d;
      out_q      <= out_d;
      of_cnt_q   <= of_cnt_d;
    end
  end

  assign ex_pc          = pc_q;
  assign ex_en          = en_q;
  assign ex_br_flag     = br_flag_q;
  assign ex_mem_op      = mem_op_q;
  assign ex_mem_wr_data = wr_data_q;
  assign ex_ctrl_op     = ctrl_op_q;
  assign ex_dst_addr    = dst_addr_q;
  assign ex_gpr_we      = gpr_we_q;
  assign ex_exp_code    = exp_code_q;
  assign ex_out         = out_q;
  assign ex_of_cnt      = of_cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: a reference model pushes expected outputs per edge,
// an independent monitor pops and compares them after each rising edge.
module tb_ex_mem_reg;

  localparam int PC_W  = 30;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            reset, stall, flush, int_detect;
    logic [PC_W-1:0] pc;
    logic            en, br;
    logic [1:0]      mem_op;
    logic [31:0]     wr_data;
    logic [1:0]      ctrl_op;
    logic [4:0]      dst;
    logic            we;
    logic [2:0]      exp;
    logic [31:0]     alu;
    logic            of;
  } in_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            en, br;
    logic [1:0]      mem_op;
    logic [31:0]     wr_data;
    logic [1:0]      ctrl_op;
    logic [4:0]      dst;
    logic            we;
    logic [2:0]      exp;
    logic [31:0]     out;
    int              cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset, stall, flush, int_detect;
  logic [PC_W-1:0] id_pc;
  logic id_en, id_br_flag, id_gpr_we, alu_of;
  logic [1:0] id_mem_op, id_ctrl_op;
  logic [31:0] id_mem_wr_data, alu_out;
  logic [4:0] id_dst_addr;
  logic [2:0] id_exp_code;
  logic [PC_W-1:0] ex_pc;
  logic ex_en, ex_br_flag, ex_gpr_we;
  logic [1:0] ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [4:0] ex_dst_addr;
  logic [2:0] ex_exp_code;
  logic [CNT_W-1:0] ex_of_cnt;

  int n_vec = 0;
  int n_err = 0;
  exp_t model;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ex_mem_reg #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_detect(int_detect),
    .id_pc(id_pc), .id_en(id_en), .id_br_flag(id_br_flag), .id_mem_op(id_mem_op),
    .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr),
    .id_gpr_we(id_gpr_we), .id_exp_code(id_exp_code), .alu_out(alu_out), .alu_of(alu_of),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we(ex_gpr_we), .ex_exp_code(ex_exp_code), .ex_out(ex_out), .ex_of_cnt(ex_of_cnt)
  );

  // Expected register contents after one edge, written straight from the priority list.
  function automatic exp_t ref_step(exp_t cur, in_t i);
    exp_t bubble;
    exp_t n;
    bubble = '0;
    bubble.cnt = cur.cnt;
    if (i.reset) return '0;
    if (i.stall) return cur;
    if (i.flush) return bubble;
    if (i.int_detect) begin
      n = bubble;
      n.pc = i.pc;
      n.en = i.en;
      n.exp = 3'd1;
      return n;
    end
    n.pc = i.pc; n.en = i.en; n.br = i.br; n.mem_op = i.mem_op; n.wr_data = i.wr_data;
    n.ctrl_op = i.ctrl_op; n.dst = i.dst; n.we = i.we; n.exp = i.exp; n.out = i.alu;
    n.cnt = cur.cnt;
    if (!i.en || i.exp != 3'd0) begin
      n.we = 1'b0;
      n.mem_op = 2'd0;
    end else if (i.of) begin
      n.we = 1'b0;
      n.mem_op = 2'd0;
      n.exp = 3'd3;
      n.cnt = (cur.cnt < CNT_MAX) ? cur.cnt + 1 : CNT_MAX;
    end
    return n;
  endfunction

  task automatic chk(string name, longint act, longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Monitor: every edge presents a new register image; compare it with the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("ex_pc", longint'(ex_pc), longint'(e.pc));
      chk("ex_en", longint'(ex_en), longint'(e.en));
      chk("ex_br_flag", longint'(ex_br_flag), longint'(e.br));
      chk("ex_mem_op", longint'(ex_mem_op), longint'(e.mem_op));
      chk("ex_mem_wr_data", longint'(ex_mem_wr_data), longint'(e.wr_data));
      chk("ex_ctrl_op", longint'(ex_ctrl_op), longint'(e.ctrl_op));
      chk("ex_dst_addr", longint'(ex_dst_addr), longint'(e.dst));
      chk("ex_gpr_we", longint'(ex_gpr_we), longint'(e.we));
      chk("ex_exp_code", longint'(ex_exp_code), longint'(e.exp));
      chk("ex_out", longint'(ex_out), longint'(e.out));
      chk("ex_of_cnt", longint'(ex_of_cnt), longint'(e.cnt));
    end
  end

  task automatic apply(in_t i);
    reset = i.reset; stall = i.stall; flush = i.flush; int_detect = i.int_detect;
    id_pc = i.pc; id_en = i.en; id_br_flag = i.br; id_mem_op = i.mem_op;
    id_mem_wr_data = i.wr_data; id_ctrl_op = i.ctrl_op; id_dst_addr = i.dst;
    id_gpr_we = i.we; id_exp_code = i.exp; alu_out = i.alu; alu_of = i.of;
    model = ref_step(model, i);
    sb_q.push_back(model);
    @(posedge clk);
    #2;
  endtask

  function automatic in_t rand_in();
    in_t i;
    i.reset = ($urandom_range(0, 49) == 0);
    i.stall = ($urandom_range(0, 7) == 0);
    i.flush = ($urandom_range(0, 9) == 0);
    i.int_detect = ($urandom_range(0, 9) == 0);
    i.pc = PC_W'($urandom);
    i.en = ($urandom_range(0, 4) != 0);
    i.br = 1'($urandom);
    i.mem_op = 2'($urandom_range(0, 2));
    i.wr_data = $urandom;
    i.ctrl_op = 2'($urandom);
    i.dst = 5'($urandom);
    i.we = 1'($urandom);
    i.exp = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
    i.alu = $urandom;
    i.of = ($urandom_range(0, 2) == 0);
    return i;
  endfunction

  in_t v;

  initial begin
    model = '0;
    v = '0;
    // reset, then a normal load
    v.reset = 1'b1;
    apply(v);
    v = '0; v.en = 1'b1; v.alu = 32'h5; v.we = 1'b1; v.dst = 5'd3;
    apply(v);
    // overflow with a store: side effects killed, counter increments
    v = '0; v.en = 1'b1; v.alu = 32'h8000_0000; v.of = 1'b1; v.we = 1'b1; v.mem_op = 2'd2;
    apply(v);
    // load pc 0x100, then stall beats flush/interrupt/overflow for 3 cycles
    v = '0; v.en = 1'b1; v.pc = 30'h100; v.alu = 32'hCAFE; v.we = 1'b1; v.dst = 5'd7;
    apply(v);
    for (int k = 0; k < 3; k++) begin
      v = rand_in();
      v.reset = 1'b0; v.stall = 1'b1; v.flush = 1'b1; v.int_detect = 1'b1;
      v.en = 1'b1; v.of = 1'b1; v.exp = 3'd0;
      apply(v);
    end
    v.stall = 1'b0; v.flush = 1'b1;
    apply(v);
    // interrupt beats overflow
    v = '0; v.int_detect = 1'b1; v.of = 1'b1; v.pc = 30'h2A; v.en = 1'b1; v.we = 1'b1;
    v.alu = 32'h1234;
    apply(v);
    // ID exception beats overflow
    v = '0; v.en = 1'b1; v.exp = 3'd2; v.of = 1'b1; v.we = 1'b1; v.mem_op = 2'd1;
    apply(v);
    // invalid slot ignores overflow and carries no side effect
    v = '0; v.en = 1'b0; v.of = 1'b1; v.we = 1'b1; v.mem_op = 2'd2; v.alu = 32'hDEAD;
    apply(v);
    // reset during stall
    v = '0; v.en = 1'b1; v.of = 1'b1; apply(v);
    v.stall = 1'b1; v.reset = 1'b1; apply(v);
    // saturation: 17 overflow loads from a clean reset
    v = '0; v.reset = 1'b1; apply(v);
    for (int k = 0; k < 17; k++) begin
      v = rand_in();
      v.reset = 1'b0; v.stall = 1'b0; v.flush = 1'b0; v.int_detect = 1'b0;
      v.en = 1'b1; v.exp = 3'd0; v.of = 1'b1;
      apply(v);
    end
    chk("of_cnt_saturated", longint'(ex_of_cnt), longint'(CNT_MAX));
    v = '0; v.en = 1'b1; v.exp = 3'd0; v.of = 1'b1; apply(v);
    v = '0; v.reset = 1'b1; apply(v);
    chk("of_cnt_after_reset", longint'(ex_of_cnt), 0);
    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      v = rand_in();
      apply(v);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register, directly downstream of the ALU.
- Captures the ALU result and overflow flag together with the control fields passed down from ID. Presents them to the MEM stage.
- Converts ALU overflow and external interrupts into exception codes. Kills register and memory side effects of faulting instructions.
- Obeys the pipeline controller's stall/flush. Keeps a saturating overflow-event counter for debug.

Parameters:
- PC_W, 30, word-address PC width
- CNT_W, 16, width of the overflow-event counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all registers
- flush  in  1  insert bubble
- int_detect  in  1  external interrupt taken at this stage
- id_pc  in  PC_W  PC of the instruction in EX
- id_en  in  1  instruction valid
- id_br_flag  in  1  branch flag
- id_mem_op  in  2  memory op: 0 NOP, 1 LDW, 2 STW
- id_mem_wr_data  in  32  store data
- id_ctrl_op  in  2  control op
- id_dst_addr  in  5  GPR write address
- id_gpr_we  in  1  GPR write enable (active-high)
- id_exp_code  in  3  exception code from ID
- alu_out  in  32  ALU result
- alu_of  in  1  ALU signed overflow
- ex_pc  out  PC_W  registered id_pc
- ex_en  out  1  registered id_en
- ex_br_flag  out  1  registered id_br_flag
- ex_mem_op  out  2  registered id_mem_op
- ex_mem_wr_data  out  32  registered id_mem_wr_data
- ex_ctrl_op  out  2  registered id_ctrl_op
- ex_dst_addr  out  5  registered id_dst_addr
- ex_gpr_we  out  1  registered id_gpr_we
- ex_exp_code  out  3  registered exception code
- ex_out  out  32  registered ALU result
- ex_of_cnt  out  CNT_W  saturating count of overflow exceptions latched

Behaviour:
- Timing: all outputs are registered and update on the rising edge of clk. Latency is 1 cycle from the inputs to the ex_* outputs. There is no combinational path from input to output.
- Exception codes: 0 NO_EXP, 1 EXT_INT, 3 OVERFLOW. Other ID codes pass through unchanged.
- "Bubble" below means:
  - ex_en=0, ex_br_flag=0, ex_mem_op=0, ex_ctrl_op=0, ex_gpr_we=0, ex_exp_code=0
  - ex_pc, ex_mem_wr_data, ex_dst_addr and ex_out are all zero.
- Priority per edge, highest first:
  1. reset: bubble and ex_of_cnt=0.
  2. stall: all ex_* and ex_of_cnt hold. stall dominates flush, int_detect and alu_of. A cleared stall resumes next edge with no lost state.
  3. flush: bubble; ex_of_cnt holds.
  4. int_detect:
     - ex_pc=id_pc, ex_en=id_en, ex_exp_code=1.
     - All other fields are the bubble value.
     - Overflow is ignored; ex_of_cnt is not incremented.
  5. id_en=1, id_exp_code!=0:
     - Load all fields, ex_exp_code=id_exp_code.
     - Force ex_gpr_we=0 and ex_mem_op=0.
     - ID exception beats overflow; no count.
  6. id_en=1, id_exp_code=0, alu_of=1:
     - Load all fields, ex_exp_code=3.
     - Force ex_gpr_we=0 and ex_mem_op=0.
     - ex_of_cnt increments, saturating at all-ones with no wrap.
  7. Otherwise: normal load of all fields; ex_exp_code=id_exp_code.
- Invalid slots (id_en=0):
  - Fields load as given; alu_of is ignored.
  - ex_gpr_we and ex_mem_op are forced to 0 so a garbage slot has no side effect.
- ex_out is always the unmodified alu_out when loaded; faulting results are still visible for debug.
- No internal FSM beyond the register/priority logic. ex_of_cnt is the only state not mirrored from inputs.
- Reset mid-stall: reset wins; outputs are the bubble value on the next edge.

Test Plan:
- Reset, then a normal load: assert reset 1 cycle; then id_en=1, alu_out=0x0000_0005, id_gpr_we=1, id_dst_addr=3, alu_of=0. Required on next edge: ex_out=5, ex_gpr_we=1, ex_dst_addr=3, ex_exp_code=0, ex_of_cnt=0.
- Overflow: alu_out=0x8000_0000, alu_of=1, id_en=1, id_gpr_we=1, id_mem_op=2. Required: ex_exp_code=3, ex_gpr_we=0, ex_mem_op=0, ex_out=0x8000_0000, ex_of_cnt=1.
- Stall with flush: first load id_pc=0x100, then hold stall=1, flush=1 and int_detect=1 for 3 cycles with new inputs. Required: outputs stay at the id_pc=0x100 values and ex_of_cnt is unchanged. Then stall=0, flush=1: bubble on the next edge.
- Interrupt vs overflow: int_detect=1, alu_of=1, id_pc=0x2A, id_en=1. Required: ex_exp_code=1, ex_pc=0x2A, ex_gpr_we=0, ex_of_cnt unchanged.
- ID exception vs overflow: id_exp_code=2, alu_of=1, id_en=1. Required: ex_exp_code=2, ex_gpr_we=0, no count. Invalid slot: id_en=0, alu_of=1, id_gpr_we=1. Required: ex_exp_code=0, ex_gpr_we=0, no count.
- Counter saturation: with CNT_W=4, apply 17 consecutive overflow loads. Required: ex_of_cnt reaches 0xF and stays 0xF. A following reset returns it to 0.
